core_run_monitor: RTL and testbench

CORE_RUN_MONITOR -- requirements
Module: core_run_monitor

---
 rtl/core_run_monitor.sv | 139 +++++++++++++
 tb/tb_core_run_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_monitor.sv
// core_run_monitor: sequences a monitored core through reset-hold and run, captures the
// results it stores to memory, and detects completion or timeout.
//
// Ports:
//   clk          - single clock, rising edge
//   areset       - synchronous active-low reset
//   start        - one-cycle pulse that begins a monitored run (honoured in IDLE/DONE/TIMEOUT)
//   mem_we       - core data-memory write enable
//   mem_addr     - core data-memory byte address
//   mem_wdata    - core data-memory write data
//   core_rst_n   - active-low reset to the monitored core (high only in RUN)
//   busy         - high in HOLD or RUN
//   done         - high in DONE
//   timed_out    - high in TIMEOUT
//   cycle_count  - RUN cycles elapsed in the current or last run (saturating)
//   result_valid - per-channel captured flag
//   result_data  - channel i at bits [i*XLEN +: XLEN]
//   done_code    - data of the completion store
module core_run_monitor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_CH      = 4,
  parameter logic [31:0] RESULT_BASE = 32'h0000_0008,
  parameter logic [31:0] DONE_ADDR   = 32'h0000_00FC,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 500
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   mem_we,
  input  logic [31:0]            mem_addr,
  input  logic [XLEN-1:0]        mem_wdata,
  output logic                   core_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out,
  output logic [31:0]            cycle_count,
  output logic [NUM_CH-1:0]      result_valid,
  output logic [NUM_CH*XLEN-1:0] result_data,
  output logic [XLEN-1:0]        done_code
);

  typedef enum logic [2:0] {StIdle, StHold, StRun, StDone, StTimeout} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              hold_cnt_q, hold_cnt_d;
  logic [31:0]              cycle_cnt_q, cycle_cnt_d;
  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [NUM_CH*XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]          code_q, code_d;

  logic                     store_ok;
  logic                     done_hit;
  logic [NUM_CH-1:0]        ch_hit;

  // Address decode; misaligned stores never match anything.
  always_comb begin
    store_ok = mem_we && (mem_addr[1:0] == 2'b00);
    done_hit = store_ok && (mem_addr == DONE_ADDR);
    ch_hit   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = store_ok && !done_hit && (mem_addr == RESULT_BASE + 32'(4 * i));
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    code_d      = code_q;
    unique case (state_q)
      StIdle, StDone, StTimeout: begin
        if (start) begin
          state_d     = StHold;
          hold_cnt_d  = '0;
          cycle_cnt_d = '0;
          valid_d     = '0;
          data_d      = '0;
          code_d      = '0;
        end
      end
      StHold: begin
        hold_cnt_d = hold_cnt_q + 32'd1;
        if (hold_cnt_q == 32'(HOLD_CYCLES - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (cycle_cnt_q != 32'hFFFF_FFFF) begin
          cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_hit[i]) begin
            valid_d[i]                = 1'b1;
            data_d[i*XLEN +: XLEN]    = mem_wdata;
          end
        end
        // Completion beats a coincident timeout.
        if (done_hit) begin
          code_d  = mem_wdata;
          state_d = StDone;
        end else if (cycle_cnt_q == 32'(TIMEOUT - 1)) begin
          state_d = StTimeout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q     <= StIdle;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      valid_q     <= '0;
      data_q      <= '0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      code_q      <= code_d;
    end
  end

  assign core_rst_n   = (state_q == StRun);
  assign busy         = (state_q == StHold) || (state_q == StRun);
  assign done         = (state_q == StDone);
  assign timed_out    = (state_q == StTimeout);
  assign cycle_count  = cycle_cnt_q;
  assign result_valid = valid_q;
  assign result_data  = data_q;
  assign done_code    = code_q;

endmodule

// File: tb/tb_core_run_monitor.sv
// Self-checking bench for core_run_monitor with HOLD_CYCLES=4 and TIMEOUT=20.
module tb_core_run_monitor;

  localparam int unsigned XL   = 32;
  localparam int unsigned NCH  = 4;
  localparam int unsigned HOLD = 4;
  localparam int unsigned TMO  = 20;

  localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DONE = 3, P_TO = 4;

  logic               clk = 1'b0;
  logic               areset, start, mem_we;
  logic [31:0]        mem_addr, mem_wdata;
  logic               core_rst_n, busy, done, timed_out;
  logic [31:0]        cycle_count;
  logic [NCH-1:0]     result_valid;
  logic [NCH*XL-1:0]  result_data;
  logic [XL-1:0]      done_code;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  core_run_monitor #(
    .XLEN        (XL),
    .NUM_CH      (NCH),
    .RESULT_BASE (32'h0000_0008),
    .DONE_ADDR   (32'h0000_00FC),
    .HOLD_CYCLES (HOLD),
    .TIMEOUT     (TMO)
  ) dut (
    .clk          (clk),
    .areset       (areset),
    .start        (start),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .done         (done),
    .timed_out    (timed_out),
    .cycle_count  (cycle_count),
    .result_valid (result_valid),
    .result_data  (result_data),
    .done_code    (done_code)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: phase, remaining hold cycles, run cycle tally, captured results.
  int          m_phase     = P_IDLE;
  int          m_hold_left = 0;
  logic [31:0] m_count     = '0;
  logic [31:0] m_code      = '0;
  logic [3:0]  m_valid     = '0;
  logic [31:0] m_res [4]   = '{default: '0};

  always @(posedge clk) begin : model
    int          ph, hl, idx;
    logic [31:0] cnt, code;
    logic [3:0]  v;
    logic [31:0] r [4];
    ph = m_phase; hl = m_hold_left; cnt = m_count; code = m_code; v = m_valid; r = m_res;
    if (!areset) begin
      ph = P_IDLE; hl = 0; cnt = 0; code = 0; v = 0;
      for (int k = 0; k < 4; k++) r[k] = 0;
    end else begin
      case (ph)
        P_IDLE, P_DONE, P_TO: begin
          if (start) begin
            ph = P_HOLD; hl = HOLD; cnt = 0; code = 0; v = 0;
            for (int k = 0; k < 4; k++) r[k] = 0;
          end
        end
        P_HOLD: begin
          hl = hl - 1;
          if (hl == 0) ph = P_RUN;
        end
        P_RUN: begin
          if (cnt != 32'hFFFF_FFFF) cnt = cnt + 1;
          if (mem_we && mem_addr[1:0] == 2'b00) begin
            if (mem_addr == 32'hFC) begin
              code = mem_wdata;
              ph   = P_DONE;
            end else if (mem_addr >= 32'h8 && (mem_addr - 32'h8) / 4 < NCH) begin
              idx    = int'((mem_addr - 32'h8) / 4);
              r[idx] = mem_wdata;
              v[idx] = 1'b1;
            end
          end
          if (ph == P_RUN && cnt == TMO) ph = P_TO;
        end
        default: ph = P_IDLE;
      endcase
    end
    m_phase     <= ph;
    m_hold_left <= hl;
    m_count     <= cnt;
    m_code      <= code;
    m_valid     <= v;
    m_res       <= r;
  end

  always @(negedge clk) begin : compare
    logic [127:0] exp_data;
    if (cmp_en) begin
      for (int k = 0; k < 4; k++) exp_data[k*32 +: 32] = m_res[k];
      chk("m_core_rst_n", core_rst_n, m_phase == P_RUN);
      chk("m_busy", busy, m_phase == P_HOLD || m_phase == P_RUN);
      chk("m_done", done, m_phase == P_DONE);
      chk("m_timed_out", timed_out, m_phase == P_TO);
      chk("m_cycle_count", cycle_count, m_count);
      chk("m_result_valid", result_valid, m_valid);
      chk("m_result_data", result_data, exp_data);
      chk("m_done_code", done_code, m_code);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    step(1);
    mem_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (!core_rst_n && n < 20) begin step(1); n++; end
    chk(name, core_rst_n, 1'b1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_core_rst_n"}, core_rst_n, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_timed_out"}, timed_out, 1'b0);
    chk({tag, "_cycle_count"}, cycle_count, 32'd0);
    chk({tag, "_result_valid"}, result_valid, 4'b0000);
    chk({tag, "_result_data"}, result_data, 128'd0);
    chk({tag, "_done_code"}, done_code, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low;
    int n;
    areset = 1'b0; start = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    step(1);
    cmp_en = 1'b1;
    step(1);
    chk_reset_state("rst");
    areset = 1'b1;
    step(1);

    // Start: core held in reset for exactly HOLD cycles; stores during HOLD are ignored.
    pulse_start();
    chk("busy_after_start", busy, 1'b1);
    low = 0;
    for (int i = 0; i < 12 && !core_rst_n; i++) begin
      low++;
      store(32'h08, 32'h5A);
    end
    chk("hold_low_cycles", low, HOLD);
    chk("hold_store_ignored", result_valid, 4'b0000);
    chk("run_first_count", cycle_count, 32'd0);

    // Out-of-range and misaligned stores.
    store(32'h18, 32'd9);
    store(32'h09, 32'd7);
    chk("bad_addr_ignored", result_valid, 4'b0000);

    // Overwrite, start ignored in RUN, then completion.
    store(32'h08, 32'd6);
    store(32'h08, 32'd3);
    chk("ch0_overwrite", result_data[31:0], 32'd3);
    chk("ch0_valid", result_valid, 4'b0001);
    pulse_start();
    chk("start_in_run_busy", busy, 1'b1);
    chk("start_in_run_core", core_rst_n, 1'b1);
    store(32'hFC, 32'd1);
    chk("done_flag", done, 1'b1);
    chk("done_code", done_code, 32'd1);
    chk("done_core_rst", core_rst_n, 1'b0);
    chk("done_valid", result_valid, 4'b0001);
    chk("done_data", result_data[31:0], 32'd3);
    step(3);
    chk("done_count_frozen", cycle_count, 32'd6);

    // Start from DONE clears results and re-enters HOLD.
    pulse_start();
    chk("restart_busy", busy, 1'b1);
    chk("restart_done", done, 1'b0);
    chk("restart_valid", result_valid, 4'b0000);
    chk("restart_code", done_code, 32'd0);

    // Timeout with no completion store.
    n = 0;
    while (!timed_out && n < 60) begin step(1); n++; end
    chk("timeout_flag", timed_out, 1'b1);
    chk("timeout_count", cycle_count, 32'd20);

    // Completion store coincident with the timeout condition wins.
    pulse_start();
    wait_run("wait_run_a");
    n = 0;
    while (cycle_count != 32'd19 && n < 40) begin step(1); n++; end
    store(32'hFC, 32'h55);
    chk("race_done", done, 1'b1);
    chk("race_timed_out", timed_out, 1'b0);
    chk("race_count", cycle_count, 32'd20);
    chk("race_code", done_code, 32'h55);

    // Reset mid-RUN after two captures.
    pulse_start();
    wait_run("wait_run_b");
    store(32'h08, 32'h11);
    store(32'h10, 32'h22);
    chk("two_caps", result_valid, 4'b0101);
    areset = 1'b0;
    step(1);
    areset = 1'b1;
    chk_reset_state("midrun");
    store(32'h08, 32'h77);
    step(2);
    chk("idle_after_reset", busy, 1'b0);
    chk("idle_store_ignored", result_valid, 4'b0000);

    // Clean run after reset.
    pulse_start();
    wait_run("wait_run_c");
    chk("clean_count0", cycle_count, 32'd0);
    store(32'h14, 32'hBEEF);
    store(32'hFC, 32'd2);
    chk("clean_valid", result_valid, 4'b1000);
    chk("clean_ch3", result_data[127:96], 32'hBEEF);
    chk("clean_done", done, 1'b1);
    chk("clean_count", cycle_count, 32'd2);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
